// File: rtl/spi_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// spi_ctrl_pkg
// Shared definitions for the SPI transaction arbiter:
//   - FSM state encodings (legacy localparam constants plus a typed enum)
//   - bit offsets of the per-requester config word {C_POL, C_PH, CLK_DIV}
//   - width of the frame/gap down-counter
// No ports (package).
// -----------------------------------------------------------------------------
package spi_ctrl_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_XFER    = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_GAP     = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_SETUP   = ST_SETUP,
        S_XFER    = ST_XFER,
        S_CAPTURE = ST_CAPTURE,
        S_GAP     = ST_GAP
    } state_e;

    // Config word layout: CLK_DIV occupies [freq_div-1:0], C_PH sits just
    // above it, C_POL is the top bit.
    localparam int CFG_DIV_LSB = 0;

    function automatic int cfg_ph_bit(input int freq_div);
        return freq_div;
    endfunction

    function automatic int cfg_pol_bit(input int freq_div);
        return freq_div + 1;
    endfunction

    // Largest frame is D_PACK << 2**freq_div; this width holds it unsigned.
    function automatic int cnt_width(input int d_pack, input int freq_div);
        return $clog2(d_pack) + (2 ** freq_div) + 1;
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// -----------------------------------------------------------------------------
// spi_rr_arbiter
// Combinational request arbiter for the SPI transaction controller.
//   SPI_ARB_RR_EN defined  : round robin, search starts at i_ptr+1 and wraps.
//   SPI_ARB_RR_EN undefined: fixed priority, lowest index wins, i_ptr ignored.
// Ports:
//   i_req     [N_REQ-1:0]  request levels
//   i_ptr     [IDX_W-1:0]  index of the last granted requester
//   o_win_oh  [N_REQ-1:0]  one-hot winner (zero when no request)
//   o_win_idx [IDX_W-1:0]  winner index
// -----------------------------------------------------------------------------
module spi_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_win_oh,
    output logic [IDX_W-1:0] o_win_idx
);

`ifdef SPI_ARB_RR_EN
    always_comb begin
        int               j;
        logic             w_found;
        logic [IDX_W-1:0] w_j;
        o_win_oh  = '0;
        o_win_idx = '0;
        w_found   = 1'b0;
        j         = 0;
        w_j       = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = int'(i_ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            w_j = IDX_W'(j);
            if (!w_found && i_req[w_j]) begin
                o_win_oh[w_j] = 1'b1;
                o_win_idx     = w_j;
                w_found       = 1'b1;
            end
        end
    end
`else
    logic w_ptr_unused;
    assign w_ptr_unused = ^i_ptr;

    always_comb begin
        logic             w_found;
        logic [IDX_W-1:0] w_j;
        o_win_oh  = '0;
        o_win_idx = '0;
        w_found   = 1'b0;
        w_j       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_j = IDX_W'(i);
            if (!w_found && i_req[w_j]) begin
                o_win_oh[w_j] = 1'b1;
                o_win_idx     = w_j;
                w_found       = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/spi_txn_arbiter.sv
// -----------------------------------------------------------------------------
// spi_txn_arbiter
// Shares one SPI master between N_REQ requesters: arbitrates, latches the
// winner's slave select / mode / divider / TX byte into the master controls,
// holds SPI_ENABLE low for exactly one frame, then returns the RX byte with a
// one-cycle DONE strobe.
// Build option: SPI_ARB_RR_EN selects round-robin arbitration (default build
// is fixed priority, lowest index wins).
// Ports:
//   CLOCK, RST (sync, active high)
//   REQ, REQ_ADDR [N_REQ]        request / slave-select levels
//   REQ_CFG  [N_REQ*(FREQ_DIV+2)] per requester {C_POL, C_PH, CLK_DIV}
//   REQ_TX   [N_REQ*D_PACK]       per requester TX byte
//   GNT, DONE [N_REQ]             one-hot grant / completion strobe
//   RX_DATA  [D_PACK]             captured RX byte
//   SPI_ENABLE (low = run), SPI_ADDR, SPI_C_POL, SPI_C_PH, SPI_CLK_DIV,
//   SPI_TX_DATA                   registered master controls
//   SPI_BUSY, SPI_RX_DATA         master status / RX byte
//
// state   | meaning
// IDLE    | sample REQ, grant winner and latch its controls
// SETUP   | controls stable, wait for master not busy, load frame count
// XFER    | SPI_ENABLE low, count down one frame
// CAPTURE | DONE strobe, RX byte valid, grant released
// GAP     | idle spacing before the next arbitration
// -----------------------------------------------------------------------------
module spi_txn_arbiter
    import spi_ctrl_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int D_PACK     = 8,
    parameter int FREQ_DIV   = 3,
    parameter int GAP_CYCLES = 2
) (
    input  logic                         CLOCK,
    input  logic                         RST,
    input  logic [N_REQ-1:0]             REQ,
    input  logic [N_REQ-1:0]             REQ_ADDR,
    input  logic [N_REQ*(FREQ_DIV+2)-1:0] REQ_CFG,
    input  logic [N_REQ*D_PACK-1:0]      REQ_TX,
    output logic [N_REQ-1:0]             GNT,
    output logic [N_REQ-1:0]             DONE,
    output logic [D_PACK-1:0]            RX_DATA,
    output logic                         SPI_ENABLE,
    output logic                         SPI_ADDR,
    output logic                         SPI_C_POL,
    output logic                         SPI_C_PH,
    output logic [FREQ_DIV-1:0]          SPI_CLK_DIV,
    output logic [D_PACK-1:0]            SPI_TX_DATA,
    input  logic                         SPI_BUSY,
    input  logic [D_PACK-1:0]            SPI_RX_DATA
);

    localparam int IDX_W   = $clog2(N_REQ);
    localparam int CFG_W   = FREQ_DIV + 2;
    localparam int CNT_W   = cnt_width(D_PACK, FREQ_DIV);
    localparam int PH_BIT  = cfg_ph_bit(FREQ_DIV);
    localparam int POL_BIT = cfg_pol_bit(FREQ_DIV);

    localparam logic [CNT_W-1:0] FRAME_BASE = CNT_W'(D_PACK);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_e              r_state;
    logic [N_REQ-1:0]    r_gnt;
    logic [N_REQ-1:0]    r_done;
    logic [D_PACK-1:0]   r_rx;
    logic                r_enable;
    logic                r_addr;
    logic                r_cpol;
    logic                r_cph;
    logic [FREQ_DIV-1:0] r_clk_div;
    logic [D_PACK-1:0]   r_tx;
    logic [CNT_W-1:0]    r_cnt;

    logic [N_REQ-1:0]    w_win_oh;
    logic [IDX_W-1:0]    w_win_idx;
    logic [IDX_W-1:0]    w_ptr;
    logic [CFG_W-1:0]    w_sel_cfg;
    logic [D_PACK-1:0]   w_sel_tx;
    logic                w_sel_addr;
    logic [FREQ_DIV:0]   w_shamt;
    logic [CNT_W-1:0]    w_frame_len;

`ifdef SPI_ARB_RR_EN
    logic [IDX_W-1:0]    r_ptr;
    assign w_ptr = r_ptr;
`else
    assign w_ptr = IDX_W'(N_REQ - 1);
`endif

    spi_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_req     (REQ),
        .i_ptr     (w_ptr),
        .o_win_oh  (w_win_oh),
        .o_win_idx (w_win_idx)
    );

    always_comb begin
        w_sel_cfg  = '0;
        w_sel_tx   = '0;
        w_sel_addr = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win_idx == IDX_W'(i)) begin
                w_sel_cfg  = REQ_CFG[i*CFG_W +: CFG_W];
                w_sel_tx   = REQ_TX[i*D_PACK +: D_PACK];
                w_sel_addr = REQ_ADDR[i];
            end
        end
    end

    // Shift amount is one bit wider than CLK_DIV so div = max does not wrap.
    assign w_shamt     = {1'b0, r_clk_div} + {{FREQ_DIV{1'b0}}, 1'b1};
    assign w_frame_len = FRAME_BASE << w_shamt;

    always_ff @(posedge CLOCK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_done    <= '0;
            r_rx      <= '0;
            r_enable  <= 1'b1;
            r_addr    <= 1'b1;
            r_cpol    <= 1'b0;
            r_cph     <= 1'b0;
            r_clk_div <= '0;
            r_tx      <= '0;
            r_cnt     <= '0;
`ifdef SPI_ARB_RR_EN
            r_ptr     <= IDX_W'(N_REQ - 1);
`endif
        end else begin
            r_done <= '0;
            case (r_state)
                S_IDLE: begin
                    if (|REQ) begin
                        r_gnt     <= w_win_oh;
                        r_addr    <= w_sel_addr;
                        r_cpol    <= w_sel_cfg[POL_BIT];
                        r_cph     <= w_sel_cfg[PH_BIT];
                        r_clk_div <= w_sel_cfg[CFG_DIV_LSB +: FREQ_DIV];
                        r_tx      <= w_sel_tx;
`ifdef SPI_ARB_RR_EN
                        r_ptr     <= w_win_idx;
`endif
                        r_state   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (!SPI_BUSY) begin
                        r_cnt    <= w_frame_len;
                        r_enable <= 1'b0;
                        r_state  <= S_XFER;
                    end
                end
                S_XFER: begin
                    // DONE, RX_DATA and the grant release all land on the
                    // edge that leaves XFER so they are coherent in CAPTURE.
                    if (r_cnt == CNT_ONE) begin
                        r_enable <= 1'b1;
                        r_rx     <= SPI_RX_DATA;
                        r_done   <= r_gnt;
                        r_gnt    <= '0;
                        r_state  <= S_CAPTURE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                S_CAPTURE: begin
                    if (GAP_CYCLES == 0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt   <= GAP_LOAD;
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_cnt == CNT_ONE) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign GNT         = r_gnt;
    assign DONE        = r_done;
    assign RX_DATA     = r_rx;
    assign SPI_ENABLE  = r_enable;
    assign SPI_ADDR    = r_addr;
    assign SPI_C_POL   = r_cpol;
    assign SPI_C_PH    = r_cph;
    assign SPI_CLK_DIV = r_clk_div;
    assign SPI_TX_DATA = r_tx;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
module tb_spi_txn_arbiter;

    localparam int N   = 4;
    localparam int DP  = 8;
    localparam int FD  = 3;
    localparam int GAP = 2;
    localparam int CW  = FD + 2;

    logic              CLOCK = 1'b0;
    logic              RST;
    logic [N-1:0]      REQ;
    logic [N-1:0]      REQ_ADDR;
    logic [N*CW-1:0]   REQ_CFG;
    logic [N*DP-1:0]   REQ_TX;
    logic [N-1:0]      GNT;
    logic [N-1:0]      DONE;
    logic [DP-1:0]     RX_DATA;
    logic              SPI_ENABLE;
    logic              SPI_ADDR;
    logic              SPI_C_POL;
    logic              SPI_C_PH;
    logic [FD-1:0]     SPI_CLK_DIV;
    logic [DP-1:0]     SPI_TX_DATA;
    logic              SPI_BUSY;
    logic [DP-1:0]     SPI_RX_DATA;

    always #5 CLOCK = ~CLOCK;

    spi_txn_arbiter #(
        .N_REQ      (N),
        .D_PACK     (DP),
        .FREQ_DIV   (FD),
        .GAP_CYCLES (GAP)
    ) dut (
        .CLOCK       (CLOCK),
        .RST         (RST),
        .REQ         (REQ),
        .REQ_ADDR    (REQ_ADDR),
        .REQ_CFG     (REQ_CFG),
        .REQ_TX      (REQ_TX),
        .GNT         (GNT),
        .DONE        (DONE),
        .RX_DATA     (RX_DATA),
        .SPI_ENABLE  (SPI_ENABLE),
        .SPI_ADDR    (SPI_ADDR),
        .SPI_C_POL   (SPI_C_POL),
        .SPI_C_PH    (SPI_C_PH),
        .SPI_CLK_DIV (SPI_CLK_DIV),
        .SPI_TX_DATA (SPI_TX_DATA),
        .SPI_BUSY    (SPI_BUSY),
        .SPI_RX_DATA (SPI_RX_DATA)
    );

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [N-1:0]  req;
        logic [FD-1:0] div;
        logic          pol;
        logic          ph;
        logic          addr;
        logic [DP-1:0] tx;
        logic [DP-1:0] miso;
        int            busy;
        bit            drop;
        int            exp_len;
    } vec_t;

    vec_t tbl[6];

`ifdef SPI_ARB_RR_EN
    int last_idx;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arbitration: who wins given the request vector.
    function automatic int model_winner(input logic [N-1:0] req);
`ifdef SPI_ARB_RR_EN
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last_idx + k) % N;
            if (req[c]) return c;
        end
`else
        for (int c = 0; c < N; c++) begin
            if (req[c]) return c;
        end
`endif
        return -1;
    endfunction

    task automatic model_grant(input int w);
`ifdef SPI_ARB_RR_EN
        last_idx = w;
`else
        if (w < 0) $display("note: model_grant with no winner");
`endif
    endtask

    task automatic model_reset();
`ifdef SPI_ARB_RR_EN
        last_idx = N - 1;
`endif
    endtask

    task automatic set_all(input logic [FD-1:0] div, input logic pol, input logic ph,
                           input logic addr, input logic [DP-1:0] tx);
        for (int i = 0; i < N; i++) begin
            REQ_CFG[i*CW +: CW] = {pol, ph, div};
            REQ_TX[i*DP +: DP]  = tx ^ DP'(i * 17);
            REQ_ADDR[i]         = addr ^ i[0];
        end
    endtask

    // One complete transaction from an idle bus; all timing expectations are
    // derived from the frame length and the busy stall length.
    task automatic do_frame(input logic [N-1:0] req, input int busy, input logic [DP-1:0] miso,
                            input bit drop, input int exp_len, input string tag);
        int            w;
        int            lat;
        int            lowcnt;
        logic [N-1:0]  oh;
        logic [CW-1:0] cfg;
        logic [DP-1:0] tx;
        logic          addr;
        w = model_winner(req);
        if (w < 0) return;
        oh     = '0;
        oh[w]  = 1'b1;
        cfg    = REQ_CFG[w*CW +: CW];
        tx     = REQ_TX[w*DP +: DP];
        addr   = REQ_ADDR[w];

        @(negedge CLOCK);
        REQ         = req;
        SPI_BUSY    = (busy > 0);
        SPI_RX_DATA = miso;
        @(posedge CLOCK); #1;
        lat = 1;
        chk({tag, ".gnt"},    32'(GNT), 32'(oh));
        chk({tag, ".en_setup"}, 32'(SPI_ENABLE), 32'd1);
        chk({tag, ".tx"},     32'(SPI_TX_DATA), 32'(tx));
        chk({tag, ".addr"},   32'(SPI_ADDR), 32'(addr));
        chk({tag, ".div"},    32'(SPI_CLK_DIV), 32'(cfg[FD-1:0]));
        chk({tag, ".cph"},    32'(SPI_C_PH), 32'(cfg[FD]));
        chk({tag, ".cpol"},   32'(SPI_C_POL), 32'(cfg[FD+1]));

        if (busy > 0) begin
            repeat (busy) @(posedge CLOCK);
            #1;
            lat += busy;
            chk({tag, ".en_stall"}, 32'(SPI_ENABLE), 32'd1);
            SPI_BUSY = 1'b0;
        end
        @(posedge CLOCK); #1;
        lat++;
        chk({tag, ".en_fall"}, 32'(SPI_ENABLE), 32'd0);

        lowcnt = 0;
        while (SPI_ENABLE === 1'b0 && lowcnt < 4200) begin
            lowcnt++;
            if (drop && lowcnt == 3) begin
                REQ                = '0;
                REQ_TX[w*DP +: DP] = ~tx;
                REQ_ADDR[w]        = ~addr;
            end
            @(posedge CLOCK); #1;
            lat++;
        end
        chk({tag, ".low_len"}, 32'(lowcnt), 32'(exp_len));
        chk({tag, ".latency"}, 32'(lat + 1), 32'(3 + exp_len + busy));
        chk({tag, ".done"},    32'(DONE), 32'(oh));
        chk({tag, ".gnt_off"}, 32'(GNT), 32'd0);
        chk({tag, ".rx"},      32'(RX_DATA), 32'(miso));
        chk({tag, ".tx_hold"}, 32'(SPI_TX_DATA), 32'(tx));
        if (drop) chk({tag, ".addr_hold"}, 32'(SPI_ADDR), 32'(addr));
        model_grant(w);

        @(negedge CLOCK);
        REQ = '0;
        @(posedge CLOCK); #1;
        chk({tag, ".done_pulse"}, 32'(DONE), 32'd0);
        repeat (GAP + 2) @(posedge CLOCK);
    endtask

    task automatic reset_dut();
        @(negedge CLOCK);
        RST = 1'b1;
        REQ = '0;
        SPI_BUSY = 1'b0;
        repeat (3) @(posedge CLOCK);
        #1;
        chk("rst.gnt",  32'(GNT), 32'd0);
        chk("rst.done", 32'(DONE), 32'd0);
        chk("rst.rx",   32'(RX_DATA), 32'd0);
        chk("rst.en",   32'(SPI_ENABLE), 32'd1);
        chk("rst.addr", 32'(SPI_ADDR), 32'd1);
        chk("rst.cpol", 32'(SPI_C_POL), 32'd0);
        chk("rst.cph",  32'(SPI_C_PH), 32'd0);
        chk("rst.div",  32'(SPI_CLK_DIV), 32'd0);
        chk("rst.tx",   32'(SPI_TX_DATA), 32'd0);
        @(negedge CLOCK);
        RST = 1'b0;
        model_reset();
    endtask

    task automatic rr_seq();
        int           w;
        int           cnt;
        int           hi;
        logic [N-1:0] oh;
        set_all('0, 1'b0, 1'b0, 1'b0, 8'h11);
        SPI_BUSY = 1'b0;
        @(negedge CLOCK);
        REQ = '1;
        for (int g = 0; g < 5; g++) begin
            w     = model_winner(REQ);
            oh    = '0;
            oh[w] = 1'b1;
            cnt = 0;
            while (GNT == '0 && cnt < 100) begin
                @(negedge CLOCK);
                cnt++;
            end
            chk($sformatf("rr.gnt%0d", g), 32'(GNT), 32'(oh));
            model_grant(w);
            cnt = 0;
            while (DONE == '0 && cnt < 200) begin
                @(negedge CLOCK);
                cnt++;
            end
            chk($sformatf("rr.done%0d", g), 32'(DONE), 32'(oh));
            if (g < 4) begin
                hi = 0;
                while (SPI_ENABLE === 1'b1 && hi < 50) begin
                    hi++;
                    @(negedge CLOCK);
                end
                chk($sformatf("rr.gap%0d", g), 32'(hi), 32'(GAP + 3));
            end
        end
        REQ = '0;
        repeat (GAP + 3) @(posedge CLOCK);
    endtask

    task automatic mid_reset_seq();
        int cnt;
        bit quiet;
        set_all('0, 1'b0, 1'b0, 1'b0, 8'h66);
        SPI_BUSY = 1'b0;
        @(negedge CLOCK);
        REQ = 4'b0001;
        cnt = 0;
        while (SPI_ENABLE !== 1'b0 && cnt < 20) begin
            @(negedge CLOCK);
            cnt++;
        end
        cnt = 1;
        while (cnt < 5 && SPI_ENABLE === 1'b0) begin
            @(negedge CLOCK);
            cnt++;
        end
        chk("mrst.in_xfer", 32'(SPI_ENABLE), 32'd0);
        RST = 1'b1;
        REQ = '0;
        @(posedge CLOCK); #1;
        chk("mrst.en",   32'(SPI_ENABLE), 32'd1);
        chk("mrst.gnt",  32'(GNT), 32'd0);
        chk("mrst.done", 32'(DONE), 32'd0);
        @(negedge CLOCK);
        RST = 1'b0;
        model_reset();
        quiet = 1'b1;
        repeat (30) begin
            @(negedge CLOCK);
            if (DONE != '0 || SPI_ENABLE !== 1'b1 || GNT != '0) quiet = 1'b0;
        end
        chk("mrst.quiet", 32'(quiet), 32'd1);
        do_frame(4'b0011, 0, 8'h99, 1'b0, 16, "mrst.next");
    endtask

    initial begin
        RST         = 1'b1;
        REQ         = '0;
        REQ_ADDR    = '0;
        REQ_CFG     = '0;
        REQ_TX      = '0;
        SPI_BUSY    = 1'b0;
        SPI_RX_DATA = '0;

        tbl[0] = '{4'b0001, 3'd0, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h3C, 0, 1'b0, 16};
        tbl[1] = '{4'b0001, 3'd0, 1'b1, 1'b0, 1'b1, 8'h5A, 8'hC3, 5, 1'b0, 16};
        tbl[2] = '{4'b0100, 3'd0, 1'b0, 1'b1, 1'b0, 8'h81, 8'h7E, 0, 1'b1, 16};
        tbl[3] = '{4'b0110, 3'd2, 1'b1, 1'b1, 1'b1, 8'h0F, 8'hF0, 1, 1'b0, 64};
        tbl[4] = '{4'b1000, 3'd7, 1'b0, 1'b1, 1'b0, 8'hE7, 8'h18, 0, 1'b0, 2048};
        tbl[5] = '{4'b1111, 3'd1, 1'b1, 1'b0, 1'b1, 8'h42, 8'hBD, 2, 1'b0, 32};

        reset_dut();

        for (int k = 0; k < 6; k++) begin
            set_all(tbl[k].div, tbl[k].pol, tbl[k].ph, tbl[k].addr, tbl[k].tx);
            do_frame(tbl[k].req, tbl[k].busy, tbl[k].miso, tbl[k].drop,
                     tbl[k].exp_len, $sformatf("vec%0d", k));
        end

        reset_dut();
        rr_seq();

        mid_reset_seq();

        for (int r = 0; r < 12; r++) begin
            logic [N-1:0] req;
            int           w;
            int           div;
            for (int i = 0; i < N; i++) begin
                REQ_CFG[i*CW +: CW] = {1'($urandom), 1'($urandom), 3'($urandom_range(0, 2))};
                REQ_TX[i*DP +: DP]  = DP'($urandom);
                REQ_ADDR[i]         = 1'($urandom);
            end
            req = N'($urandom_range(1, (1 << N) - 1));
            w   = model_winner(req);
            div = int'(REQ_CFG[w*CW +: FD]);
            do_frame(req, int'($urandom_range(0, 3)), DP'($urandom), 1'b0,
                     DP * (1 << (div + 1)), $sformatf("rnd%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_txn_arbiter.md
# spi_txn_arbiter

Transaction controller that shares one SPI master between `N_REQ` requesters. It arbitrates pending requests, loads the winner's mode, clock divider and TX byte into the master, and holds the master's `ENABLE` low for exactly one frame. It then returns the received byte with a one-cycle `DONE` strobe. It sits between the bus-side clients and the SPI master, and is the only agent driving the master's control inputs.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `D_PACK`, 8: bits per SPI frame; must match the master.
- `FREQ_DIV`, 3: width of the clock-divider code; must match the master.
- `GAP_CYCLES`, 2: idle `CLOCK` cycles with `ENABLE` high between frames (0..15).

- `CLOCK`  in  1  system clock; all logic on rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `REQ`  in  N_REQ  per-requester request level.
- `REQ_ADDR`  in  N_REQ  per-requester slave-select level.
- `REQ_CFG`  in  N_REQ*(FREQ_DIV+2)  per-requester config, packed as {C_POL, C_PH, CLK_DIV}; requester i occupies slice i.
- `REQ_TX`  in  N_REQ*D_PACK  per-requester TX byte; requester i occupies slice i.
- `GNT`  out  N_REQ  one-hot grant, held for the whole transaction.
- `DONE`  out  N_REQ  one-cycle completion strobe for the granted requester.
- `RX_DATA`  out  D_PACK  received byte; valid while `DONE` is nonzero, held until the next capture.
- `SPI_ENABLE`  out  1  master enable; low means run, high means idle.
- `SPI_ADDR`, `SPI_C_POL`, `SPI_C_PH`  out  1 each  registered master controls.
- `SPI_CLK_DIV`  out  FREQ_DIV  registered master divider code.
- `SPI_TX_DATA`  out  D_PACK  registered master TX byte.
- `SPI_BUSY`  in  1  master busy flag.
- `SPI_RX_DATA`  in  D_PACK  master RX byte.

## Operation
- States: IDLE, SETUP, XFER, CAPTURE, GAP.
- **IDLE**
  - If `REQ` is nonzero, select the winner and register its one-hot `GNT`.
  - Latch the winner's ADDR, CFG and TX into the `SPI_*` registers.
  - Go to SETUP.
- **SETUP**
  - `SPI_ENABLE` stays 1.
  - Wait while `SPI_BUSY`=1.
  - When `SPI_BUSY`=0, load the frame counter with `D_PACK << (CLK_DIV+1)` and go to XFER.
- **XFER**
  - `SPI_ENABLE`=0.
  - Counter decrements every cycle.
  - When the counter reaches 1, go to CAPTURE.
- **CAPTURE**
  - `SPI_ENABLE`=1.
  - Register `SPI_RX_DATA` into `RX_DATA`.
  - Pulse `DONE` for the granted requester and clear `GNT`.
  - Go to GAP, or directly to IDLE if `GAP_CYCLES`=0.
- **GAP**
  - Count `GAP_CYCLES`, then go to IDLE.
- **Counter width:** `$clog2(D_PACK) + 2**FREQ_DIV + 1` bits, unsigned; it never wraps.
- **Request rules**
  - `REQ` is sampled only in IDLE.
  - Dropping `REQ` after the grant is ignored; the frame completes and `DONE` still pulses.
  - A requester holds `REQ` until it sees its `DONE`. A `REQ` still high in the cycle after `DONE` is treated as a new request.
- **Latched values:** requester ADDR/CFG/TX changes after the grant have no effect until the next grant.
- **Reset values** (also applied on `RST` mid-transaction; no `DONE` is issued for the aborted frame)
  - `GNT`=0, `DONE`=0, `RX_DATA`=0.
  - `SPI_ENABLE`=1, `SPI_ADDR`=1, `SPI_C_POL`=0, `SPI_C_PH`=0, `SPI_CLK_DIV`=0, `SPI_TX_DATA`=0.
  - State=IDLE, round-robin pointer = `N_REQ`-1, so requester 0 wins first.

## Timing
- IDLE to SETUP: 1 cycle.
- SETUP: minimum 1 cycle; the `SPI_*` controls are stable at least 1 cycle before `SPI_ENABLE` falls.
- XFER: `SPI_ENABLE` is low for exactly `D_PACK*2^(CLK_DIV+1)` cycles.
- **Request-to-DONE latency, idle bus, `SPI_BUSY`=0:** 3 + `D_PACK*2^(CLK_DIV+1)` cycles.
  - Counted from the cycle `REQ` is first sampled high in IDLE to the `DONE` cycle.
- **Back-to-back frames:** `SPI_ENABLE` is high for `GAP_CYCLES`+3 cycles between frames.
  - CAPTURE, the GAP cycles, IDLE and SETUP each contribute.
- `GNT` rises the cycle after the request is sampled and falls in the same cycle `DONE` is high.

## Configuration
- Macro: `SPI_ARB_RR_EN`.
- **Defined:** round-robin arbitration.
  - The search starts at the index after the last granted one and wraps from `N_REQ`-1 to 0.
  - The pointer updates only on grant.
- **Undefined:** fixed priority; the lowest index wins and no pointer register exists.

## Structure
- Package `spi_ctrl_pkg` holds:
  - the state enum (IDLE, SETUP, XFER, CAPTURE, GAP);
  - the CFG field offsets (CLK_DIV LSBs, C_PH, C_POL);
  - a counter-width function of `D_PACK` and `FREQ_DIV`.
- Sub-module `spi_rr_arbiter`:
  - inputs: `REQ`, pointer;
  - outputs: one-hot winner and winner index;
  - holds the `SPI_ARB_RR_EN` logic.

## Test plan
- **Single request.** `REQ`=0001, CFG {0,0,div=0}, TX=8'hA5, MISO model returns 8'h3C.
  - Required: `SPI_ENABLE` low for 16 cycles, `DONE`=0001 at cycle 19, `RX_DATA`=8'h3C.
- **Round robin.** `REQ`=1111 held continuously.
  - Required: grants in order 0001, 0010, 0100, 1000, 0001.
  - Without `SPI_ARB_RR_EN`: every grant is 0001.
- **Busy stall.** `SPI_BUSY` held 1 for 5 cycles after the grant.
  - Required: `SPI_ENABLE` falls in the cycle after `SPI_BUSY` drops, and stays low exactly 16 cycles.
- **Divider extreme.** div=7, `D_PACK`=8.
  - Required: `SPI_ENABLE` low for 2048 cycles; counter does not overflow.
- **Mid-frame reset.** `RST` asserted in the 5th XFER cycle.
  - Required: next edge gives `SPI_ENABLE`=1, `GNT`=0, no `DONE`, state IDLE; the following request wins requester 0.
- **Request withdrawn and data changed.** `REQ` dropped and `REQ_TX` changed during XFER.
  - Required: the original byte is transmitted and `DONE` still pulses for that requester.
